// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and default width.
package serial_subtractor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// 1-bit combinational full subtractor cell: d = a - b - bin, bout = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: Res = {borrow_out, A - B}, one bit per clock, LSB first,
// with a start/busy/done handshake toward the control unit.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   Res,
  output logic             zero
);

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   idx;
  logic               br;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   diff_sh;
  logic [WIDTH-1:0]   diff_next;
  logic               d;
  logic               bout;
  logic               accept;
  logic               last;

  full_subtractor u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (br),
    .d    (d),
    .bout (bout)
  );

  assign accept    = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last      = (idx == CNT_W'(WIDTH - 1));
  // New bit enters at the MSB so the first (LSB) bit ends up in position 0 after WIDTH shifts.
  assign diff_next = {d, diff_sh[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      br      <= 1'b0;
      a_sh    <= '0;
      b_sh    <= '0;
      diff_sh <= '0;
      Res     <= '0;
      zero    <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        a_sh <= A;
        b_sh <= B;
        br   <= 1'b0;
        idx  <= '0;
      end else if (state == ST_RUN) begin
        a_sh    <= a_sh >> 1;
        b_sh    <= b_sh >> 1;
        br      <= bout;
        idx     <= idx + CNT_W'(1);
        diff_sh <= diff_next;
        if (last) begin
          Res  <= {bout, diff_next};
          zero <= (diff_next == '0);
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last) state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = start ? ST_RUN : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus randomized operands against
// a plain-arithmetic reference of unsigned subtraction with borrow.
module tb_serial_subtractor;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W:0]   Res;
  logic         zero;

  int tests;
  int fails;

  serial_subtractor #(.WIDTH(W), .CNT_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Res   (Res),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] diff;
    diff = a - b;
    return {(a < b), diff};
  endfunction

  // Issues one start (called at a negedge), scrambles A/B during RUN and waits for done.
  // Returns at the negedge of the done cycle.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output int busy_cnt, output bit ok,
                       output logic [W:0] res_first, output int overlap);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
    lat = 0;
    busy_cnt = 0;
    ok = 1'b0;
    overlap = 0;
    res_first = 'x;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) res_first = Res;
      if (busy) busy_cnt++;
      if (busy && done) overlap++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy, done, zero, Res} !== '0) begin
      fails++;
      $display("FAIL reset: busy=%b done=%b zero=%b Res=%b, required all 0", busy, done, zero, Res);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] av [5] = '{4'd9, 4'd3, 4'd7, 4'd15, 4'd0};
    logic [W-1:0] bv [5] = '{4'd3, 4'd9, 4'd7, 4'd0, 4'd15};
    logic [W:0]   exp_res;
    logic [W:0]   rf;
    int lat, bc, ov;
    bit ok;
    for (int i = 0; i < 5; i++) begin
      exp_res = ref_sub(av[i], bv[i]);
      do_op(av[i], bv[i], lat, bc, ok, rf, ov);
      tests++;
      if (!ok || lat != W + 1 || bc != W || ov != 0) begin
        fails++;
        $display("FAIL directed_timing %0d: ok=%0d lat=%0d busy_cycles=%0d overlap=%0d, required ok=1 lat=%0d busy_cycles=%0d overlap=0",
                 i, ok, lat, bc, ov, W + 1, W);
      end
      tests++;
      if (Res !== exp_res || zero !== (exp_res[W-1:0] == '0)) begin
        fails++;
        $display("FAIL directed_result %0d-%0d: Res=%b zero=%b, required Res=%b zero=%b",
                 av[i], bv[i], Res, zero, exp_res, (exp_res[W-1:0] == '0));
      end
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || busy !== 1'b0 || Res !== exp_res) begin
        fails++;
        $display("FAIL directed_hold %0d: done=%b busy=%b Res=%b, required done=0 busy=0 Res=%b",
                 i, done, busy, Res, exp_res);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [W:0] rf;
    int lat, bc, ov, extra;
    bit ok;
    A = 4'd9;
    B = 4'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    A = 4'd1;
    B = 4'd1;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    lat = 2;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    tests++;
    if (!ok || lat != W + 1 || Res !== 5'b0_0110) begin
      fails++;
      $display("FAIL ignore_start: ok=%0d lat=%0d Res=%b, required ok=1 lat=%0d Res=00110", ok, lat, Res, W + 1);
    end
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    tests++;
    if (extra != 0) begin
      fails++;
      $display("FAIL ignore_start_single_done: extra done pulses=%0d, required 0", extra);
    end
    rf = '0; bc = 0; ov = 0;
  endtask

  task automatic test_abort();
    logic [W:0] rf;
    int lat, bc, ov, seen;
    bit ok;
    A = 4'd9;
    B = 4'd3;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || Res !== '0 || zero !== 1'b0) begin
      fails++;
      $display("FAIL abort_state: busy=%b done=%b Res=%b zero=%b, required 0 0 00000 0", busy, done, Res, zero);
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL abort_no_done: busy/done cycles=%0d, required 0", seen);
    end
    do_op(4'd5, 4'd2, lat, bc, ok, rf, ov);
    tests++;
    if (!ok || lat != W + 1 || Res !== 5'b0_0011 || zero !== 1'b0) begin
      fails++;
      $display("FAIL abort_recover: ok=%0d lat=%0d Res=%b zero=%b, required ok=1 lat=%0d Res=00011 zero=0",
               ok, lat, Res, zero, W + 1);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [W:0] rf;
    int lat, bc, ov;
    bit ok;
    do_op(4'd12, 4'd5, lat, bc, ok, rf, ov);
    tests++;
    if (!ok || Res !== 5'b0_0111) begin
      fails++;
      $display("FAIL b2b_first: ok=%0d Res=%b, required ok=1 Res=00111", ok, Res);
    end
    do_op(4'd0, 4'd1, lat, bc, ok, rf, ov);
    tests++;
    if (!ok || lat != W + 1 || ov != 0) begin
      fails++;
      $display("FAIL b2b_spacing: ok=%0d lat=%0d overlap=%0d, required ok=1 lat=%0d overlap=0", ok, lat, ov, W + 1);
    end
    tests++;
    if (rf !== 5'b0_0111) begin
      fails++;
      $display("FAIL b2b_res_held_during_run: Res=%b, required 00111", rf);
    end
    tests++;
    if (Res !== 5'b1_1111 || zero !== 1'b0) begin
      fails++;
      $display("FAIL b2b_second: Res=%b zero=%b, required Res=11111 zero=0", Res, zero);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic [W:0]   exp_res;
    logic [W:0]   prev;
    logic [W:0]   rf;
    int lat, bc, ov;
    bit ok;
    prev = Res;
    for (int i = 0; i < 30; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      if (i % 7 == 0) b = a;
      exp_res = ref_sub(a, b);
      do_op(a, b, lat, bc, ok, rf, ov);
      tests++;
      if (!ok || lat != W + 1 || bc != W || ov != 0 || rf !== prev) begin
        fails++;
        $display("FAIL random_handshake %0d: ok=%0d lat=%0d busy_cycles=%0d overlap=%0d res_in_run=%b, required ok=1 lat=%0d busy_cycles=%0d overlap=0 res_in_run=%b",
                 i, ok, lat, bc, ov, rf, W + 1, W, prev);
      end
      tests++;
      if (Res !== exp_res || zero !== (a == b)) begin
        fails++;
        $display("FAIL random_result %0d-%0d: Res=%b zero=%b, required Res=%b zero=%b",
                 a, b, Res, zero, exp_res, (a == b));
      end
      prev = exp_res;
      if ($urandom_range(1, 0) == 1) @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    start = 1'b0;
    A = '0;
    B = '0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
